borrow_lookahead_sub16_pipe: RTL

- 16-bit two-stage pipelined subtractor: D = X - Y - Bin.
- It is the subtract direction of the team's 16-bit carry-lookahead adder datapath.
- Stage 1 resolves the low byte. Stage 2 resolves the high byte and the flags.
- Uses valid/ready handshakes on both ends so it can sit between streaming producers and consumers in the ALU path.

---
 rtl/borrow_lookahead_sub16_pipe_if.sv | 28 ++
 rtl/borrow_lookahead_sub16_pipe.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/borrow_lookahead_sub16_pipe_if.sv
// Operand/result stream bundle for the pipelined 16-bit borrow-lookahead subtractor.
// SUB_SATURATE_EN adds the sat_mode sideband that travels with each operand beat.
interface borrow_lookahead_sub16_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] X;
  logic [15:0] Y;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] D;
  logic        Bout;
  logic        V;
  logic        Z;
`ifdef SUB_SATURATE_EN
  logic        sat_mode;

  modport slave  (input  in_valid, X, Y, Bin, sat_mode, out_ready,
                  output in_ready, out_valid, D, Bout, V, Z);
  modport master (output in_valid, X, Y, Bin, sat_mode, out_ready,
                  input  in_ready, out_valid, D, Bout, V, Z);
`else
  modport slave  (input  in_valid, X, Y, Bin, out_ready,
                  output in_ready, out_valid, D, Bout, V, Z);
  modport master (output in_valid, X, Y, Bin, out_ready,
                  input  in_ready, out_valid, D, Bout, V, Z);
`endif
endinterface

// File: rtl/borrow_lookahead_sub16_pipe.sv
// Two-stage 16-bit subtractor D = X - Y - Bin built as X + ~Y + ~Bin with group lookahead.
// Stage 1 resolves the low byte, stage 2 the high byte and flags; SUB_SATURATE_EN adds unsigned floor.
module borrow_lookahead_sub16_pipe #(
  parameter int unsigned GROUP = 4
) (
  input logic                          clk,
  input logic                          rst,
  borrow_lookahead_sub16_pipe_if.slave bus
);

  localparam int unsigned NG = 8 / GROUP;

  // 8-bit adder: GROUP-wide lookahead inside groups, flat sum-of-products across groups
  function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [7:0]    g;
    logic [7:0]    p;
    logic [7:0]    c;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;
    logic          acc;
    logic          t;
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    gg = '0;
    gp = '0;
    gc = '0;
    for (int k = 0; k < int'(NG); k++) begin
      gg[k] = 1'b0;
      gp[k] = 1'b1;
      for (int j = 0; j < int'(GROUP); j++) begin
        gg[k] = g[k*GROUP+j] | (p[k*GROUP+j] & gg[k]);
        gp[k] = gp[k] & p[k*GROUP+j];
      end
    end
    gc[0] = cin;
    for (int k = 0; k < int'(NG); k++) begin
      acc = cin;
      for (int m = 0; m <= k; m++) acc = acc & gp[m];
      for (int j = 0; j <= k; j++) begin
        t = gg[j];
        for (int m = j + 1; m <= k; m++) t = t & gp[m];
        acc = acc | t;
      end
      gc[k+1] = acc;
    end
    for (int k = 0; k < int'(NG); k++) begin
      for (int j = 0; j < int'(GROUP); j++) begin
        acc = gc[k];
        for (int m = 0; m < j; m++) acc = acc & p[k*GROUP+m];
        for (int i = 0; i < j; i++) begin
          t = g[k*GROUP+i];
          for (int m = i + 1; m < j; m++) t = t & p[k*GROUP+m];
          acc = acc | t;
        end
        c[k*GROUP+j] = acc;
      end
    end
    return {gc[NG], p ^ c};
  endfunction

  logic        r_s1_valid;
  logic [7:0]  r_s1_d_lo;
  logic        r_s1_b8;
  logic [7:0]  r_s1_xh;
  logic [7:0]  r_s1_yh;
  logic        r_s1_sat;

  logic        r_out_valid;
  logic [15:0] r_d;
  logic        r_bout;
  logic        r_v;
  logic        r_z;

  logic        w_adv2;
  logic        w_in_ready;
  logic        w_sat_in;
  logic [8:0]  w_lo;
  logic [8:0]  w_hi;
  logic [15:0] w_d_raw;
  logic [15:0] w_d;
  logic        w_bout;
  logic        w_v;

  assign w_adv2     = !r_out_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_adv2;

`ifdef SUB_SATURATE_EN
  assign w_sat_in = bus.sat_mode;
`else
  assign w_sat_in = 1'b0;
`endif

  // Stage 1 low byte; carry-in is the inverted borrow-in
  assign w_lo = cla8(bus.X[7:0], ~bus.Y[7:0], ~bus.Bin);

  // Stage 2 high byte continues from the registered borrow out of bit 7
  assign w_hi    = cla8(r_s1_xh, ~r_s1_yh, ~r_s1_b8);
  assign w_d_raw = {w_hi[7:0], r_s1_d_lo};
  assign w_bout  = ~w_hi[8];
  assign w_v     = (r_s1_xh[7] != r_s1_yh[7]) && (w_d_raw[15] != r_s1_xh[7]);
  assign w_d     = (r_s1_sat && w_bout) ? 16'h0000 : w_d_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_d_lo  <= '0;
      r_s1_b8    <= 1'b0;
      r_s1_xh    <= '0;
      r_s1_yh    <= '0;
      r_s1_sat   <= 1'b0;
    end else if (w_in_ready) begin
      r_s1_valid <= bus.in_valid;
      r_s1_d_lo  <= w_lo[7:0];
      r_s1_b8    <= ~w_lo[8];
      r_s1_xh    <= bus.X[15:8];
      r_s1_yh    <= bus.Y[15:8];
      r_s1_sat   <= w_sat_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_d         <= '0;
      r_bout      <= 1'b0;
      r_v         <= 1'b0;
      r_z         <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      r_d         <= w_d;
      r_bout      <= w_bout;
      r_v         <= w_v;
      r_z         <= ~|w_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.D         = r_d;
  assign bus.Bout      = r_bout;
  assign bus.V         = r_v;
  assign bus.Z         = r_z;

endmodule
